// File: rtl/pktgen_sequencer.sv
`timescale 1ns/1ps
// Run controller for the two packet-generator channels: alignment check, parallel or
// serial launch, busy-handshake supervision, timeout/abort/link-loss handling.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a run request
// CHECK     | verify mask non-empty and enabled channels PCS-aligned
// LAUNCH    | ch_start pulse visible for the current launch set
// WAIT_ACK  | waiting for every launched channel to raise busy
// WAIT_DONE | waiting for every launched channel to drop busy
// FINISH    | emit done, release run_busy
module pktgen_sequencer #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               serial,
    input  logic [1:0]         chan_mask,
    input  logic [COUNT_W-1:0] packet_count,
    input  logic [1:0]         eth_aligned,
    input  logic [1:0]         ch_busy,
    output logic [1:0]         ch_start,
    output logic [1:0]         ch_abort,
    output logic [COUNT_W-1:0] ch_count,
    output logic               run_busy,
    output logic               done,
    output logic [2:0]         status,
    output logic [1:0]         fail_mask
);

    localparam int               TMO_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ACK_TIMEOUT);

    localparam logic [2:0] ST_OK          = 3'd0;
    localparam logic [2:0] ST_NOT_ALIGNED = 3'd1;
    localparam logic [2:0] ST_TIMEOUT     = 3'd2;
    localparam logic [2:0] ST_LINK_LOST   = 3'd3;
    localparam logic [2:0] ST_EMPTY_MASK  = 3'd4;
    localparam logic [2:0] ST_ABORTED     = 3'd5;

    typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH} state_t;

    state_t           state;
    logic             serial_q;
    logic [1:0]       mask_q;
    logic [1:0]       ran_q;
    logic [1:0]       launch_q;
    logic [1:0]       seen_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic [1:0]       remaining;
    logic [1:0]       next_set;
    logic [1:0]       seen_nx;
    logic [1:0]       lost;
    logic [TMO_W-1:0] tmo_nx;

    always_comb begin
        remaining = mask_q & ~ran_q;
        next_set  = mask_q;
        if (serial_q) begin
            if (remaining[0])      next_set = 2'b01;
            else if (remaining[1]) next_set = 2'b10;
            else                   next_set = 2'b00;
        end
        seen_nx = seen_q | (ch_busy & launch_q);
        lost    = launch_q & ~eth_aligned;
        tmo_nx  = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_W'(1);
    end

    // ch_start is registered on entry to LAUNCH so the pulse coincides with that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            serial_q  <= 1'b0;
            mask_q    <= '0;
            ran_q     <= '0;
            launch_q  <= '0;
            seen_q    <= '0;
            tmo_cnt   <= '0;
            ch_start  <= '0;
            ch_abort  <= '0;
            ch_count  <= '0;
            run_busy  <= 1'b0;
            done      <= 1'b0;
            status    <= ST_OK;
            fail_mask <= '0;
        end else begin
            ch_start <= '0;
            ch_abort <= '0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        serial_q  <= serial;
                        mask_q    <= chan_mask;
                        ch_count  <= packet_count;
                        ran_q     <= '0;
                        status    <= ST_OK;
                        fail_mask <= '0;
                        run_busy  <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (mask_q == 2'b00) begin
                        status <= ST_EMPTY_MASK;
                        state  <= FINISH;
                    end else if ((mask_q & ~eth_aligned) != 2'b00) begin
                        status    <= ST_NOT_ALIGNED;
                        fail_mask <= mask_q & ~eth_aligned;
                        state     <= FINISH;
                    end else begin
                        ch_start <= next_set;
                        launch_q <= next_set;
                        ran_q    <= ran_q | next_set;
                        seen_q   <= '0;
                        tmo_cnt  <= '0;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    seen_q  <= seen_nx;
                    tmo_cnt <= tmo_nx;
                    if (abort) begin
                        status   <= ST_ABORTED;
                        ch_abort <= launch_q;
                        state    <= FINISH;
                    end else if (lost != 2'b00) begin
                        status    <= ST_LINK_LOST;
                        fail_mask <= lost;
                        ch_abort  <= launch_q;
                        state     <= FINISH;
                    end else if (seen_nx == launch_q) begin
                        state <= WAIT_DONE;
                    end else if (tmo_nx == TMO_MAX) begin
                        status    <= ST_TIMEOUT;
                        fail_mask <= launch_q & ~seen_nx;
                        ch_abort  <= launch_q;
                        state     <= FINISH;
                    end
                end
                WAIT_DONE: begin
                    if (abort) begin
                        status   <= ST_ABORTED;
                        ch_abort <= launch_q;
                        state    <= FINISH;
                    end else if (lost != 2'b00) begin
                        status    <= ST_LINK_LOST;
                        fail_mask <= lost;
                        ch_abort  <= launch_q;
                        state     <= FINISH;
                    end else if ((ch_busy & launch_q) == 2'b00) begin
                        if (serial_q && (remaining != 2'b00)) begin
                            ch_start <= next_set;
                            launch_q <= next_set;
                            ran_q    <= ran_q | next_set;
                            seen_q   <= '0;
                            tmo_cnt  <= '0;
                            state    <= LAUNCH;
                        end else begin
                            status <= ST_OK;
                            state  <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    run_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
